// File: rtl/ray_dispatcher_pkg.sv
// Shared ray/colour field definitions for the dispatcher and the tracer.
package ray_dispatcher_pkg;

    localparam int unsigned INIT_W  = 28;
    localparam int unsigned DIR_W   = 31;
    localparam int unsigned COLOR_W = 12;

    localparam int unsigned X_W  = 10;
    localparam int unsigned Y_W  = 9;
    localparam int unsigned Z_W  = 9;
    localparam int unsigned DX_W = 11;
    localparam int unsigned DY_W = 10;
    localparam int unsigned DZ_W = 10;

    localparam int unsigned INIT_Z_LSB = 0;
    localparam int unsigned INIT_Y_LSB = INIT_Z_LSB + Z_W;
    localparam int unsigned INIT_X_LSB = INIT_Y_LSB + Y_W;
    localparam int unsigned DIR_DZ_LSB = 0;
    localparam int unsigned DIR_DY_LSB = DIR_DZ_LSB + DZ_W;
    localparam int unsigned DIR_DX_LSB = DIR_DY_LSB + DY_W;

    localparam logic [COLOR_W-1:0] BLACK = 12'h000;
    localparam logic [COLOR_W-1:0] WHITE = 12'hFFF;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [Z_W-1:0] z;
    } ray_init_t;

    typedef struct packed {
        logic [DX_W-1:0] dx;
        logic [DY_W-1:0] dy;
        logic [DZ_W-1:0] dz;
    } ray_dir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } disp_state_e;

endpackage

// File: rtl/ray_dispatcher_tag_delay.sv
// Fixed-depth {valid, addr} shift register tracking rays through the tracer pipeline.
module ray_tag_delay #(
    parameter int unsigned DEPTH  = 38,
    parameter int unsigned ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr
);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];

    // Shift every stage by one per clock, new tag enters stage 0.
    always_comb begin
        valid_d[0] = in_valid;
        addr_d[0]  = in_addr;
        for (int i = 1; i < int'(DEPTH); i++) begin
            valid_d[i] = valid_q[i-1];
            addr_d[i]  = addr_q[i-1];
        end
    end

    // Stage registers; reset empties the line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) addr_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < int'(DEPTH); i++) addr_q[i] <= addr_d[i];
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];

endmodule

// File: rtl/ray_dispatcher.sv
// Frame sweeper: issues one primary ray per clock and writes returned pixels to VRAM.
module ray_dispatcher
    import ray_dispatcher_pkg::*;
#(
    parameter int unsigned    H_RES          = 640,
    parameter int unsigned    V_RES          = 480,
    parameter int unsigned    ADDR_W         = 19,
    parameter int unsigned    TRACER_LATENCY = 38,
    parameter logic [DZ_W-1:0] FOCAL         = 10'd256,
    parameter logic [X_W-1:0]  CAM_X         = 10'd320,
    parameter logic [Y_W-1:0]  CAM_Y         = 9'd240,
    parameter logic [Z_W-1:0]  CAM_Z         = 9'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [INIT_W-1:0]  init,
    output logic [DIR_W-1:0]   dir,
    input  logic [COLOR_W-1:0] tr_dout,
    input  logic               tr_collision,
    output logic               vram_we,
    output logic [ADDR_W-1:0]  vram_addr,
    output logic [COLOR_W-1:0] vram_data,
    output logic               busy,
    output logic               frame_done,
    output logic [ADDR_W-1:0]  hit_count
);

    localparam int unsigned COL_W     = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned ROW_W     = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int unsigned LAST_COL  = H_RES - 1;
    localparam int unsigned LAST_ROW  = V_RES - 1;
    localparam int unsigned LAST_ADDR = H_RES * V_RES - 1;

    disp_state_e       state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] issue_addr_q, issue_addr_d;
    logic              ray_valid_q, ray_valid_d;
    logic [ADDR_W-1:0] ray_addr_q, ray_addr_d;
    ray_init_t         init_q, init_d;
    ray_dir_t          dir_q, dir_d;
    logic [ADDR_W-1:0] hit_q, hit_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;

    logic              tail_valid;
    logic [ADDR_W-1:0] tail_addr;

    ray_tag_delay #(
        .DEPTH  (TRACER_LATENCY),
        .ADDR_W (ADDR_W)
    ) u_tag_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ray_valid_q),
        .in_addr   (ray_addr_q),
        .out_valid (tail_valid),
        .out_addr  (tail_addr)
    );

    // Next-state, ray generation, pixel counters and collision counting.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        issue_addr_d = issue_addr_q;
        ray_valid_d  = 1'b0;
        ray_addr_d   = ray_addr_q;
        init_d       = init_q;
        dir_d        = dir_q;
        hit_d        = hit_q;
        frame_done_d = 1'b0;

        if (tail_valid && tr_collision && (hit_q != '1)) begin
            hit_d = hit_q + ADDR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_ISSUE;
                    col_d        = '0;
                    row_d        = '0;
                    issue_addr_d = '0;
                    hit_d        = '0;
                end
            end
            ST_ISSUE: begin
                ray_valid_d  = 1'b1;
                ray_addr_d   = issue_addr_q;
                init_d.x     = CAM_X;
                init_d.y     = CAM_Y;
                init_d.z     = CAM_Z;
                dir_d.dx     = DX_W'(col_q) - DX_W'(H_RES / 2);
                dir_d.dy     = DY_W'(V_RES / 2) - DY_W'(row_q);
                dir_d.dz     = FOCAL;
                issue_addr_d = issue_addr_q + ADDR_W'(1);
                if (col_q == COL_W'(LAST_COL)) begin
                    col_d = '0;
                    if (row_q == ROW_W'(LAST_ROW)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            ST_DRAIN: begin
                if (tail_valid && (tail_addr == ADDR_W'(LAST_ADDR))) begin
                    state_d      = ST_DONE;
                    frame_done_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            issue_addr_q <= '0;
            ray_valid_q  <= 1'b0;
            ray_addr_q   <= '0;
            init_q       <= '0;
            dir_q        <= '0;
            hit_q        <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            issue_addr_q <= issue_addr_d;
            ray_valid_q  <= ray_valid_d;
            ray_addr_q   <= ray_addr_d;
            init_q       <= init_d;
            dir_q        <= dir_d;
            hit_q        <= hit_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign init       = init_q;
    assign dir        = dir_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign hit_count  = hit_q;

    // Write port follows the tag line tail; colour comes straight from the tracer.
    assign vram_we   = tail_valid;
    assign vram_addr = tail_valid ? tail_addr : '0;
    assign vram_data = tail_valid ? tr_dout : BLACK;

endmodule

// File: tb/tb_ray_dispatcher.sv
// Self-checking bench for ray_dispatcher: small 4x2 frame plus a wide 640x16 frame.
module tb_ray_dispatcher;
    import ray_dispatcher_pkg::*;

    localparam int S_H = 4, S_V = 2, S_L = 5, S_N = S_H * S_V, S_AW = 3;
    localparam int B_H = 640, B_V = 16, B_L = 38, B_N = B_H * B_V, B_AW = 19;
    localparam int S_HIT_MAX = (1 << S_AW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // small instance
    logic               s_start, s_tr_col, s_we, s_busy, s_done;
    logic [INIT_W-1:0]  s_init;
    logic [DIR_W-1:0]   s_dir;
    logic [COLOR_W-1:0] s_tr_dout, s_vdata;
    logic [S_AW-1:0]    s_vaddr, s_hits;
    logic [7:0]         coll_mask_s;

    // wide instance
    logic               b_start, b_tr_col, b_we, b_busy, b_done;
    logic [INIT_W-1:0]  b_init;
    logic [DIR_W-1:0]   b_dir;
    logic [COLOR_W-1:0] b_tr_dout, b_vdata;
    logic [B_AW-1:0]    b_vaddr, b_hits;

    ray_dispatcher #(.H_RES(S_H), .V_RES(S_V), .ADDR_W(S_AW), .TRACER_LATENCY(S_L)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .init(s_init), .dir(s_dir),
        .tr_dout(s_tr_dout), .tr_collision(s_tr_col), .vram_we(s_we),
        .vram_addr(s_vaddr), .vram_data(s_vdata), .busy(s_busy),
        .frame_done(s_done), .hit_count(s_hits)
    );

    ray_dispatcher #(.H_RES(B_H), .V_RES(B_V), .ADDR_W(B_AW), .TRACER_LATENCY(B_L)) u_big (
        .clk(clk), .rst(rst), .start(b_start), .init(b_init), .dir(b_dir),
        .tr_dout(b_tr_dout), .tr_collision(b_tr_col), .vram_we(b_we),
        .vram_addr(b_vaddr), .vram_data(b_vdata), .busy(b_busy),
        .frame_done(b_done), .hit_count(b_hits)
    );

    // Pixel index a primary ray points at, recovered from its direction.
    function automatic int pix_of(input logic [DIR_W-1:0] d, input int h, input int v);
        logic signed [DX_W-1:0] dx;
        logic signed [DY_W-1:0] dy;
        dx = d[DIR_DX_LSB +: DX_W];
        dy = d[DIR_DY_LSB +: DY_W];
        return (v / 2 - int'(dy)) * h + int'(dx) + h / 2;
    endfunction

    function automatic logic [COLOR_W-1:0] colour_of(input int i);
        return WHITE ^ COLOR_W'(i * 149 + 17);
    endfunction

    function automatic logic [DIR_W-1:0] exp_dir(input int p, input int h, input int v);
        int dx, dy;
        dx = (p % h) - h / 2;
        dy = v / 2 - (p / h);
        return {DX_W'(dx), DY_W'(dy), 10'd256};
    endfunction

    // Behavioural tracers: fixed latency, colour and collision derived from the ray's pixel.
    logic [DIR_W-1:0] s_pipe [S_L];
    logic [DIR_W-1:0] b_pipe [B_L];
    int s_idx, b_idx;

    always @(posedge clk) begin
        for (int i = S_L - 1; i > 0; i--) s_pipe[i] <= s_pipe[i-1];
        s_pipe[0] <= s_dir;
        for (int j = B_L - 1; j > 0; j--) b_pipe[j] <= b_pipe[j-1];
        b_pipe[0] <= b_dir;
    end

    always_comb begin
        s_idx     = pix_of(s_pipe[S_L-1], S_H, S_V);
        s_tr_dout = colour_of(s_idx);
        s_tr_col  = (s_idx >= 0 && s_idx < S_N) ? (((coll_mask_s >> s_idx) & 8'd1) != 8'd0) : 1'b0;
        b_idx     = pix_of(b_pipe[B_L-1], B_H, B_V);
        b_tr_dout = colour_of(b_idx);
        b_tr_col  = (b_idx >= 0 && b_idx < B_N) && (b_idx % 7 == 3);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_small_idle(input string name);
        chk({name, "_init"}, s_init, 0);
        chk({name, "_dir"}, s_dir, 0);
        chk({name, "_we"}, s_we, 0);
        chk({name, "_vaddr"}, s_vaddr, 0);
        chk({name, "_vdata"}, s_vdata, 0);
        chk({name, "_busy"}, s_busy, 0);
        chk({name, "_done"}, s_done, 0);
        chk({name, "_hits"}, s_hits, 0);
    endtask

    // One small frame; spur >= 1 pulses start again so it is sampled at edge spur+1.
    task automatic run_small_frame(input logic [7:0] mask, input int spur, input int exp_hits,
                                   input string tag);
        logic [DIR_W-1:0] px0, px7;
        logic exp_we;
        int w;
        px0 = {11'h7FE, 10'd1, 10'd256};
        px7 = {11'd1, 10'd0, 10'd256};
        coll_mask_s = mask;
        @(negedge clk) s_start = 1'b1;
        @(negedge clk) s_start = 1'b0;
        for (int c = 1; c <= S_N + S_L + 4; c++) begin
            @(negedge clk);
            s_start = 1'b0;
            exp_we = (c >= S_L + 1) && (c <= S_L + S_N);
            chk({tag, "_we"}, s_we, exp_we);
            if (exp_we) begin
                w = c - S_L - 1;
                chk({tag, "_vaddr"}, s_vaddr, w);
                chk({tag, "_vdata"}, s_vdata, colour_of(w));
            end else begin
                chk({tag, "_bus_idle"}, {s_vaddr, s_vdata}, 0);
            end
            chk({tag, "_busy"}, s_busy, (c <= S_N + S_L));
            chk({tag, "_done"}, s_done, (c == S_N + S_L + 1));
            if (c <= S_N) chk({tag, "_dir"}, s_dir, exp_dir(c - 1, S_H, S_V));
            if (c == 1) begin
                chk({tag, "_hits_clr"}, s_hits, 0);
                chk({tag, "_dir_px0"}, s_dir, px0);
                chk({tag, "_init_x"}, s_init[INIT_X_LSB +: X_W], 320);
                chk({tag, "_init_y"}, s_init[INIT_Y_LSB +: Y_W], 240);
                chk({tag, "_init_z"}, s_init[INIT_Z_LSB +: Z_W], 0);
                chk({tag, "_dz"}, s_dir[DIR_DZ_LSB +: DZ_W], 256);
            end
            if (c == S_N + S_L + 2) chk({tag, "_dir_hold_px7"}, s_dir, px7);
            if (c == spur) s_start = 1'b1;
        end
        chk({tag, "_hits"}, s_hits, exp_hits);
    endtask

    typedef struct {
        logic [7:0] mask;
        int         spur;
        int         exp_hits;
    } frame_vec_t;

    initial begin
        frame_vec_t vecs [4];
        logic [7:0] rmask;
        int rspur, rhits, any_we, any_done, any_busy;
        int wcount, bad, last_addr, fall_c, done_c, exp_b_hits;

        vecs[0] = '{mask: 8'b0010_0100, spur: -1, exp_hits: 2};
        vecs[1] = '{mask: 8'h00, spur: 3, exp_hits: 0};
        vecs[2] = '{mask: 8'hFF, spur: 10, exp_hits: 7};
        vecs[3] = '{mask: 8'h81, spur: S_N + S_L + 1, exp_hits: 2};

        rst = 1'b0;
        s_start = 1'b0;
        b_start = 1'b0;
        coll_mask_s = 8'h00;
        repeat (3) @(negedge clk);
        chk_small_idle("reset");
        rst = 1'b1;
        @(negedge clk);

        // table-driven frames
        for (int v = 0; v < 4; v++) begin
            run_small_frame(vecs[v].mask, vecs[v].spur, vecs[v].exp_hits, $sformatf("vec%0d", v));
        end

        // reset mid-ISSUE after three rays have been issued
        coll_mask_s = 8'hFF;
        @(negedge clk) s_start = 1'b1;
        @(negedge clk) s_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", s_busy, 1);
        rst = 1'b0;
        #1;
        chk_small_idle("mid_rst");
        @(negedge clk) rst = 1'b1;
        any_we = 0;
        any_done = 0;
        any_busy = 0;
        for (int c = 0; c < S_N + S_L + 6; c++) begin
            @(negedge clk);
            if (s_we) any_we++;
            if (s_done) any_done++;
            if (s_busy) any_busy++;
        end
        chk("after_rst_no_we", any_we, 0);
        chk("after_rst_no_done", any_done, 0);
        chk("after_rst_no_busy", any_busy, 0);
        run_small_frame(8'b0010_0100, -1, 2, "post_rst");

        // randomized frames against the model
        for (int r = 0; r < 6; r++) begin
            rmask = 8'($urandom);
            rspur = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, S_N + S_L + 1)) : -1;
            rhits = $countones(rmask);
            if (rhits > S_HIT_MAX) rhits = S_HIT_MAX;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_small_frame(rmask, rspur, rhits, $sformatf("rnd%0d", r));
        end

        // wide frame: 640-pixel rows, 38-cycle latency
        exp_b_hits = 0;
        for (int i = 0; i < B_N; i++) if (i % 7 == 3) exp_b_hits++;
        wcount = 0;
        bad = 0;
        last_addr = -1;
        fall_c = -1;
        done_c = -1;
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        for (int c = 1; c <= B_N + B_L + 10; c++) begin
            @(negedge clk);
            if (b_we) begin
                if (int'(b_vaddr) != wcount || b_vdata != colour_of(wcount)) bad++;
                last_addr = int'(b_vaddr);
                wcount++;
            end
            if (!b_busy && fall_c < 0) fall_c = c;
            if (b_done) done_c = c;
        end
        chk("big_writes", wcount, B_N);
        chk("big_write_order", bad, 0);
        chk("big_last_addr", last_addr, B_N - 1);
        chk("big_busy_fall", fall_c, B_N + B_L + 1);
        chk("big_done_cycle", done_c, B_N + B_L + 1);
        chk("big_hits", b_hits, exp_b_hits);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
